// File: rtl/sram_ctrl_pkg.sv
// -----------------------------------------------------------------------------
// sram_ctrl_pkg
//   Shared types and constants for the SRAM controller slice.
//   - state_t     : controller FSM states
//   - SRAM_*      : SRAM address/data widths and default timing
//   - word_index(): byte address -> 16-bit SRAM word index relative to a base
// -----------------------------------------------------------------------------
package sram_ctrl_pkg;

   localparam int          SRAM_AW           = 16;
   localparam int          SRAM_DW           = 32;
   localparam int          LINE_W            = 2 * SRAM_DW;
   localparam int          SRAM_WAIT_DEFAULT = 4;
   localparam logic [31:0] MEM_BASE_DEFAULT  = 32'd1024;

   typedef enum logic [2:0] {
      IDLE,
      RD0,
      RD1,
      WR,
      DONE
   } state_t;

   // Addresses below the base wrap modulo 2^16 words; no range check is made.
   function automatic logic [SRAM_AW-1:0] word_index(input logic [31:0] addr,
                                                     input logic [31:0] base);
      return SRAM_AW'((addr - base) >> 2);
   endfunction

endpackage

// File: rtl/sram_wait_counter.sv
// -----------------------------------------------------------------------------
// sram_wait_counter
//   Counts cycles an SRAM word access has been held. Counts 0..SRAM_WAIT-1.
//   Ports:
//     clk  in  system clock
//     rst  in  asynchronous active-high reset
//     clr  in  synchronous clear (takes priority over en)
//     en   in  count enable
//     tc   out terminal count: counter is at SRAM_WAIT-1
// -----------------------------------------------------------------------------
module sram_wait_counter #(
   parameter int SRAM_WAIT = 4
) (
   input  logic clk,
   input  logic rst,
   input  logic clr,
   input  logic en,
   output logic tc
);

   localparam int CW = (SRAM_WAIT > 1) ? $clog2(SRAM_WAIT) : 1;

   logic [CW-1:0] cnt;

   // NOTE: clocked state uses non-blocking assignments so every register
   // samples pre-edge values regardless of process ordering.
   always_ff @(posedge clk or posedge rst) begin
      if (rst)      cnt <= '0;
      else if (clr) cnt <= '0;
      else if (en)  cnt <= cnt + 1'b1;
   end

   assign tc = (cnt == CW'(SRAM_WAIT - 1));

endmodule

// File: rtl/sram_controller.sv
// -----------------------------------------------------------------------------
// sram_controller
//   Sequences an asynchronous SRAM on behalf of the cache. A read fetches the
//   8-byte-aligned line (even word, then odd word); a write stores one word.
//   Each SRAM word access is held for SRAM_WAIT cycles.
//   Ports:
//     clk, rst      clock, asynchronous active-high reset
//     rd_en, wr_en  requests, held by requester until ready=1 (write wins)
//     address       byte address of request
//     write_data    word to store on write
//     read_data     registered line {word@odd, word@even}
//     ready         1 = idle with no request, or access completing this cycle
//     WE_N_SRAM     SRAM write enable, active low
//     address_SRAM  SRAM word address
//     data_SRAM     bidirectional SRAM data bus, driven only while writing
// -----------------------------------------------------------------------------
module sram_controller
   import sram_ctrl_pkg::*;
#(
   parameter int          SRAM_WAIT = SRAM_WAIT_DEFAULT,
   parameter logic [31:0] MEM_BASE  = MEM_BASE_DEFAULT
) (
   input  logic                 clk,
   input  logic                 rst,
   input  logic                 rd_en,
   input  logic                 wr_en,
   input  logic [31:0]          address,
   input  logic [31:0]          write_data,
   output logic [LINE_W-1:0]    read_data,
   output logic                 ready,
   output logic                 WE_N_SRAM,
   output logic [SRAM_AW-1:0]   address_SRAM,
   inout  wire  [SRAM_DW-1:0]   data_SRAM
);

   state_t              state, next_state;
   logic [SRAM_AW-1:0]  widx_q;
   logic [SRAM_DW-1:0]  wdata_q;
   logic                cnt_tc, cnt_en, cnt_clr;
   logic                accept;

   assign accept = (state == IDLE) && (rd_en || wr_en);

   // ---------------- FSM ----------------
   always_ff @(posedge clk or posedge rst) begin
      if (rst) state <= IDLE;
      else     state <= next_state;
   end

   // NOTE: every signal assigned in a combinational block gets a default
   // first, so no path leaves it unassigned and no latch is inferred.
   always_comb begin
      next_state = state;
      unique case (state)
         IDLE: begin
            if (wr_en)      next_state = WR;
            else if (rd_en) next_state = RD0;
         end
         RD0:  if (cnt_tc) next_state = RD1;
         RD1:  if (cnt_tc) next_state = DONE;
         WR:   if (cnt_tc) next_state = DONE;
         DONE: next_state = IDLE;
         default: next_state = IDLE;
      endcase
   end

   // Counter runs only inside an access phase and restarts at every state
   // change, so each of RD0/RD1/WR starts from zero.
   assign cnt_en  = (state == RD0) || (state == RD1) || (state == WR);
   assign cnt_clr = !cnt_en || (next_state != state);

   sram_wait_counter #(
      .SRAM_WAIT (SRAM_WAIT)
   ) u_wait (
      .clk (clk),
      .rst (rst),
      .clr (cnt_clr),
      .en  (cnt_en),
      .tc  (cnt_tc)
   );

   // ---------------- SRAM side ----------------
   // Decoded straight from the state register so reset releases the write
   // strobe immediately, without waiting for a clock edge.
   always_comb begin
      WE_N_SRAM    = 1'b1;
      address_SRAM = '0;
      unique case (state)
         RD0: address_SRAM = {widx_q[SRAM_AW-1:1], 1'b0};
         RD1: address_SRAM = {widx_q[SRAM_AW-1:1], 1'b1};
         WR: begin
            address_SRAM = widx_q;
            WE_N_SRAM    = 1'b0;
         end
         default: ;
      endcase
   end

   // Bus is driven exactly while WE_N_SRAM is low, so the SRAM never drives
   // at the same time.
   assign data_SRAM = (state == WR) ? wdata_q : 'z;

   assign ready = (state == DONE) || ((state == IDLE) && !rd_en && !wr_en);

   // ---------------- request / data registers ----------------
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         widx_q  <= '0;
         wdata_q <= '0;
      end else if (accept) begin
         widx_q  <= word_index(address, MEM_BASE);
         wdata_q <= write_data;
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         read_data <= '0;
      end else if (cnt_tc) begin
         if (state == RD0) read_data[SRAM_DW-1:0]      <= data_SRAM;
         if (state == RD1) read_data[LINE_W-1:SRAM_DW] <= data_SRAM;
      end
   end

endmodule

// File: tb/tb_sram_controller.sv
// -----------------------------------------------------------------------------
// tb_sram_controller
//   Directed bench: sram_controller plus a behavioural SRAM on the shared bus.
// -----------------------------------------------------------------------------
module tb_sram_controller;

   logic        clk = 1'b0;
   logic        rst;
   logic        rd_en, wr_en;
   logic [31:0] address, write_data;
   logic [63:0] read_data;
   logic        ready;
   logic        WE_N_SRAM;
   logic [15:0] address_SRAM;
   wire  [31:0] data_SRAM;

   int compared   = 0;
   int mismatched = 0;

   logic [31:0] mem [0:65535];

   always #5 clk = ~clk;

   sram_controller dut (
      .clk          (clk),
      .rst          (rst),
      .rd_en        (rd_en),
      .wr_en        (wr_en),
      .address      (address),
      .write_data   (write_data),
      .read_data    (read_data),
      .ready        (ready),
      .WE_N_SRAM    (WE_N_SRAM),
      .address_SRAM (address_SRAM),
      .data_SRAM    (data_SRAM)
   );

   // Behavioural SRAM: drives the bus whenever not being written.
   assign data_SRAM = WE_N_SRAM ? mem[address_SRAM] : 'z;
   always @(posedge clk) if (!WE_N_SRAM) mem[address_SRAM] <= data_SRAM;

   // Issue one request at a falling edge and follow it to ready=1, dropping
   // the request there. Returns latency, WE_N low cycles, ready in the request
   // cycle and the SRAM address seen in the 1st and 5th cycles.
   task automatic do_req(input logic rd, input logic wr,
                         input logic [31:0] addr, input logic [31:0] wdat,
                         output int lat, output int we_low, output logic rdy0,
                         output logic [15:0] a1, output logic [15:0] a5);
      @(negedge clk);
      rd_en = rd; wr_en = wr; address = addr; write_data = wdat;
      lat = 0; we_low = 0; a1 = '0; a5 = '0;
      #1 rdy0 = ready;
      for (int i = 0; i < 40; i++) begin
         @(negedge clk);
         lat++;
         if (!WE_N_SRAM) we_low++;
         if (lat == 1) a1 = address_SRAM;
         if (lat == 5) a5 = address_SRAM;
         if (ready) break;
      end
      rd_en = 1'b0; wr_en = 1'b0;
   endtask

   task automatic test_idle;
      compared++; if (ready !== 1'b1) begin mismatched++; $display("FAIL idle_ready: got %b want 1", ready); end
      compared++; if (WE_N_SRAM !== 1'b1) begin mismatched++; $display("FAIL idle_we_n: got %b want 1", WE_N_SRAM); end
      compared++; if (read_data !== 64'h0) begin mismatched++; $display("FAIL idle_read_data: got %h want 0", read_data); end
   endtask

   task automatic test_write;
      int lat, we_low; logic rdy0; logic [15:0] a1, a5;
      do_req(1'b0, 1'b1, 32'd1024, 32'hDEADBEEF, lat, we_low, rdy0, a1, a5);
      compared++; if (rdy0 !== 1'b0) begin mismatched++; $display("FAIL wr_ready_req: got %b want 0", rdy0); end
      compared++; if (lat !== 5) begin mismatched++; $display("FAIL wr_latency: got %0d want 5", lat); end
      compared++; if (we_low !== 4) begin mismatched++; $display("FAIL wr_we_low: got %0d want 4", we_low); end
      compared++; if (a1 !== 16'd0) begin mismatched++; $display("FAIL wr_addr: got %h want 0", a1); end
      compared++; if (mem[0] !== 32'hDEADBEEF) begin mismatched++; $display("FAIL wr_mem0: got %h want deadbeef", mem[0]); end
   endtask

   task automatic test_read_line;
      int lat, we_low; logic rdy0; logic [15:0] a1, a5;
      do_req(1'b0, 1'b1, 32'd1028, 32'd11, lat, we_low, rdy0, a1, a5);
      do_req(1'b0, 1'b1, 32'd1024, 32'd22, lat, we_low, rdy0, a1, a5);
      compared++; if (mem[1] !== 32'd11) begin mismatched++; $display("FAIL rl_mem1: got %h want b", mem[1]); end
      do_req(1'b1, 1'b0, 32'd1024, 32'h0, lat, we_low, rdy0, a1, a5);
      compared++; if (lat !== 9) begin mismatched++; $display("FAIL rl_latency: got %0d want 9", lat); end
      compared++; if (we_low !== 0) begin mismatched++; $display("FAIL rl_we_low: got %0d want 0", we_low); end
      compared++; if (read_data !== 64'h0000000B_00000016) begin mismatched++; $display("FAIL rl_data: got %h want 0000000b00000016", read_data); end
   endtask

   task automatic test_read_odd;
      int lat, we_low; logic rdy0; logic [15:0] a1, a5;
      do_req(1'b1, 1'b0, 32'd1028, 32'h0, lat, we_low, rdy0, a1, a5);
      compared++; if (rdy0 !== 1'b0) begin mismatched++; $display("FAIL ro_ready_req: got %b want 0", rdy0); end
      compared++; if (a1 !== 16'd0) begin mismatched++; $display("FAIL ro_addr_even: got %h want 0", a1); end
      compared++; if (a5 !== 16'd1) begin mismatched++; $display("FAIL ro_addr_odd: got %h want 1", a5); end
      compared++; if (lat !== 9) begin mismatched++; $display("FAIL ro_latency: got %0d want 9", lat); end
      compared++; if (read_data !== 64'h0000000B_00000016) begin mismatched++; $display("FAIL ro_data: got %h want 0000000b00000016", read_data); end
   endtask

   task automatic test_both_req;
      int lat, we_low; logic rdy0; logic [15:0] a1, a5;
      do_req(1'b1, 1'b1, 32'd1032, 32'd7, lat, we_low, rdy0, a1, a5);
      compared++; if (lat !== 5) begin mismatched++; $display("FAIL both_latency: got %0d want 5", lat); end
      compared++; if (we_low !== 4) begin mismatched++; $display("FAIL both_we_low: got %0d want 4", we_low); end
      compared++; if (mem[2] !== 32'd7) begin mismatched++; $display("FAIL both_mem2: got %h want 7", mem[2]); end
      compared++; if (read_data !== 64'h0000000B_00000016) begin mismatched++; $display("FAIL both_rd_kept: got %h want 0000000b00000016", read_data); end
   endtask

   // Reset while a write is in progress.
   task automatic test_reset;
      @(negedge clk);
      wr_en = 1'b1; address = 32'd1424; write_data = 32'h12345678;
      repeat (3) @(negedge clk);
      compared++; if (WE_N_SRAM !== 1'b0) begin mismatched++; $display("FAIL rst_in_wr: got %b want 0", WE_N_SRAM); end
      rst = 1'b1;
      #1;
      compared++; if (WE_N_SRAM !== 1'b1) begin mismatched++; $display("FAIL rst_we_n: got %b want 1", WE_N_SRAM); end
      compared++; if (address_SRAM !== 16'd0) begin mismatched++; $display("FAIL rst_addr: got %h want 0", address_SRAM); end
      compared++; if (read_data !== 64'h0) begin mismatched++; $display("FAIL rst_read_data: got %h want 0", read_data); end
      compared++; if (data_SRAM !== 32'd22) begin mismatched++; $display("FAIL rst_bus_released: got %h want 16", data_SRAM); end
      wr_en = 1'b0;
      #1;
      compared++; if (ready !== 1'b1) begin mismatched++; $display("FAIL rst_ready: got %b want 1", ready); end
      @(negedge clk);
      rst = 1'b0;
   endtask

   // Reset in the third cycle of RD1, then a fresh read of another line.
   task automatic test_reset_rd1;
      int lat, we_low; logic rdy0; logic [15:0] a1, a5;
      @(negedge clk);
      rd_en = 1'b1; address = 32'd1024;
      repeat (7) @(negedge clk);
      compared++; if (address_SRAM !== 16'd1) begin mismatched++; $display("FAIL r6_in_rd1: got %h want 1", address_SRAM); end
      compared++; if (read_data !== 64'h16) begin mismatched++; $display("FAIL r6_low_latched: got %h want 16", read_data); end
      rst = 1'b1;
      #1;
      compared++; if (read_data !== 64'h0) begin mismatched++; $display("FAIL r6_read_data: got %h want 0", read_data); end
      compared++; if (address_SRAM !== 16'd0) begin mismatched++; $display("FAIL r6_idle_addr: got %h want 0", address_SRAM); end
      compared++; if (ready !== 1'b0) begin mismatched++; $display("FAIL r6_ready_held: got %b want 0", ready); end
      rd_en = 1'b0;
      @(negedge clk);
      rst = 1'b0;
      do_req(1'b1, 1'b0, 32'd1032, 32'h0, lat, we_low, rdy0, a1, a5);
      compared++; if (lat !== 9) begin mismatched++; $display("FAIL r6_latency: got %0d want 9", lat); end
      compared++; if (a1 !== 16'd2) begin mismatched++; $display("FAIL r6_addr_even: got %h want 2", a1); end
      compared++; if (read_data !== 64'hA5A50003_00000007) begin mismatched++; $display("FAIL r6_data: got %h want a5a5000300000007", read_data); end
   endtask

   initial begin
      for (int i = 0; i < 65536; i++) mem[i] = 32'hA5A5_0000 | i;
      rst = 1'b1; rd_en = 1'b0; wr_en = 1'b0; address = '0; write_data = '0;
      repeat (2) @(negedge clk);
      rst = 1'b0;
      @(negedge clk);
      test_idle();
      test_write();
      test_read_line();
      test_read_odd();
      test_both_req();
      test_reset();
      test_idle();
      test_reset_rd1();
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
      $finish;
   end

endmodule
